// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - segment glyphs, conversion FSM state type and helpers for disp_iface
package disp_pkg;

  // Active-high {g,f,e,d,c,b,a}; entry n is the glyph for digit n
  localparam logic [9:0][6:0] SEG_DIG = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} disp_state_t;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_DIG[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter, one input bit per cycle
module bin2bcd_seq #(
  parameter int VAL_W = 14,
  parameter int NDIG  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VAL_W-1:0]        mag,
  output logic                    done,
  output logic [4*(NDIG+1)-1:0]   bcd
);

  localparam int BCD_W = 4 * (NDIG + 1);
  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] r_mag;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic [BCD_W-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NDIG + 1; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_mag <= mag;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_mag[VAL_W-1]};
      r_mag <= {r_mag[VAL_W-2:0], 1'b0};
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(VAL_W - 1)) r_run <= 1'b0;
    end
  end

  // done marks the final shift cycle; bcd holds the result from the next cycle on
  assign done = r_run && (r_cnt == CNT_W'(VAL_W - 1));
  assign bcd  = r_bcd;

endmodule

// File: rtl/disp_iface.sv
// rtl/disp_iface.sv - multiplexed NDIG-digit 7-segment driver for a signed binary result
// Optional LZ_BLANK_EN: blank leading zeros and place the minus sign beside the leading digit.
module disp_iface
  import disp_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int VAL_W       = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic [6:0]       seg,
  output logic [NDIG-1:0]  an
);

  localparam int BCD_W  = 4 * (NDIG + 1);
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int SCAN_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [6:0]      SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NDIG-1:0] AN_OFF  = (SEG_ACT_LOW != 0) ? '1 : '0;

  disp_state_t            r_state, w_state_nxt;
  logic                   r_sign, r_ovf;
  logic [NDIG-1:0][6:0]   r_disp, w_disp_fmt, w_disp_rst;
  logic                   w_start, w_done, w_ovf_in, w_ovf;
  logic [VAL_W-1:0]       w_mag;
  logic [BCD_W-1:0]       w_bcd;
  logic [REF_W-1:0]       r_refresh;
  logic [SCAN_W-1:0]      r_scan;
  logic [NDIG-1:0]        w_an_hot;
  logic [6:0]             r_seg;
  logic [NDIG-1:0]        r_an;

  assign w_mag    = value[VAL_W-1] ? -value : value;
  assign w_ovf_in = value[VAL_W-1] ? (32'(w_mag) >= pow10(NDIG - 1))
                                   : (32'(w_mag) >= pow10(NDIG));

  bin2bcd_seq #(.VAL_W(VAL_W), .NDIG(NDIG)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .mag   (w_mag),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE:    if (load) begin
                 w_start     = 1'b1;
                 w_state_nxt = CONV;
               end
      CONV:    if (w_done) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  always_comb begin
    w_disp_rst = '0;
    for (int i = 0; i < NDIG; i++) begin
`ifdef LZ_BLANK_EN
      w_disp_rst[i] = (i == 0) ? SEG_DIG[0] : SEG_BLANK;
`else
      w_disp_rst[i] = SEG_DIG[0];
`endif
    end
  end

  // Any carry into the extra nibble is overflow whatever the threshold
  assign w_ovf = r_ovf || (w_bcd[BCD_W-1 -: 4] != 4'd0);

`ifdef LZ_BLANK_EN
  int w_msd;
`endif

  always_comb begin
    w_disp_fmt = '0;
`ifdef LZ_BLANK_EN
    w_msd = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (w_bcd[4*i +: 4] != 4'd0) w_msd = i;
    end
`endif
    if (w_ovf) begin
      w_disp_fmt[0] = SEG_E;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
`ifdef LZ_BLANK_EN
        if (i <= w_msd) w_disp_fmt[i] = digit_seg(w_bcd[4*i +: 4]);
        else if (r_sign && (i == w_msd + 1)) w_disp_fmt[i] = SEG_MINUS;
`else
        w_disp_fmt[i] = digit_seg(w_bcd[4*i +: 4]);
        if (r_sign && (i == NDIG - 1)) w_disp_fmt[i] = SEG_MINUS;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_ovf   <= 1'b0;
      r_disp  <= w_disp_rst;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_sign <= value[VAL_W-1];
        r_ovf  <= w_ovf_in;
      end
      if (r_state == COMMIT) r_disp <= w_disp_fmt;
    end
  end

  assign w_an_hot = NDIG'(1) << r_scan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh <= '0;
      r_scan    <= '0;
      r_an      <= AN_OFF;
      r_seg     <= SEG_OFF;
    end else begin
      if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
        r_refresh <= '0;
        r_scan    <= (r_scan == SCAN_W'(NDIG - 1)) ? '0 : r_scan + SCAN_W'(1);
      end else begin
        r_refresh <= r_refresh + REF_W'(1);
      end
      r_an  <= (SEG_ACT_LOW != 0) ? ~w_an_hot : w_an_hot;
      r_seg <= (SEG_ACT_LOW != 0) ? ~r_disp[r_scan] : r_disp[r_scan];
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_disp_iface.sv
// tb/tb_disp_iface.sv - randomized self-checking bench for disp_iface against a formatted-text display model
`timescale 1ns/1ps
module tb_disp_iface;

  localparam int NDIG        = 4;
  localparam int VAL_W       = 14;
  localparam int REFRESH_DIV = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [VAL_W-1:0] value = '0;
  logic             busy;
  logic [6:0]       seg;
  logic [NDIG-1:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  disp_iface #(
    .NDIG(NDIG), .VAL_W(VAL_W), .REFRESH_DIV(REFRESH_DIV), .SEG_ACT_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] seg_char(input logic [6:0] s);
    logic [6:0] h;
    h = ~s;
    case (h)
      7'h3F: return "0";
      7'h06: return "1";
      7'h5B: return "2";
      7'h4F: return "3";
      7'h66: return "4";
      7'h6D: return "5";
      7'h7D: return "6";
      7'h07: return "7";
      7'h7F: return "8";
      7'h6F: return "9";
      7'h40: return "-";
      7'h79: return "E";
      7'h00: return " ";
      default: return "?";
    endcase
  endfunction

  // Expected four-character display text, leftmost digit in the top byte
  function automatic logic [31:0] model(input int v);
    string s;
    int    mag;
    bit    neg;
    neg = (v < 0);
    mag = neg ? -v : v;
    if ((!neg && mag >= 10 ** NDIG) || (neg && mag >= 10 ** (NDIG - 1))) s = "   E";
    else begin
`ifdef LZ_BLANK_EN
      s = $sformatf("%4d", v);
`else
      s = neg ? $sformatf("-%03d", mag) : $sformatf("%04d", mag);
`endif
    end
    return {s[0], s[1], s[2], s[3]};
  endfunction

  task automatic read_display(output logic [31:0] shown);
    logic [7:0]      ch [NDIG];
    logic [NDIG-1:0] sel;
    for (int i = 0; i < NDIG; i++) ch[i] = 8'h3F;
    for (int k = 0; k < 2 * NDIG * REFRESH_DIV; k++) begin
      step();
      for (int i = 0; i < NDIG; i++) begin
        sel = ~(NDIG'(1) << i);
        if (an == sel) ch[i] = seg_char(seg);
      end
    end
    shown = {ch[3], ch[2], ch[1], ch[0]};
  endtask

  task automatic apply(input int v, input int intr_at, input int intr_v);
    int          cnt;
    logic [31:0] shown;
    value = VAL_W'(v);
    load  = 1'b1;
    step();
    load = 1'b0;
    cnt  = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (cnt == intr_at) begin
        value = VAL_W'(intr_v);
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;
    chk($sformatf("busy_len %0d", v), cnt, 15);
    read_display(shown);
    chk($sformatf("disp %0d", v), shown, model(v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]     shown;
    logic [NDIG-1:0] exp_an;
    int              dir [8] = '{1234, -42, 8191, -8192, -999, -1000, 0, -1};
    int              v;

    rst = 1'b1;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);

    rst = 1'b0;
    for (int k = 0; k < 4 * NDIG; k++) begin
      step();
      exp_an = ~(NDIG'(1) << ((k / REFRESH_DIV) % NDIG));
      chk($sformatf("scan_an %0d", k), an, exp_an);
      chk("scan_busy", busy, 0);
    end
    read_display(shown);
    chk("reset_disp", shown, model(0));

    foreach (dir[i]) apply(dir[i], 0, 0);

    apply(5555, 3, 7777);
    step();
    chk("idle_after_ignored", busy, 0);

    value = VAL_W'(9876);
    load  = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    chk("midconv_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_an", an, 4'hF);
    read_display(shown);
    chk("abort_disp", shown, model(0));
    apply(1, 0, 0);

    for (int r = 0; r < 16; r++) begin
      if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 2000)) - 1000;
      else begin
        v = int'($urandom_range(0, 16383));
        if (v >= 8192) v = v - 16384;
      end
      if ($urandom_range(0, 2) == 0) apply(v, int'($urandom_range(1, 12)), int'($urandom_range(0, 16383)));
      else apply(v, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
